// File: rtl/rs232_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rs232_rx
//  Purpose  : 8N1 UART receiver (LSB first). The line passes through a 2-FF
//             synchronizer and is sampled at mid-bit. Received bytes go to a
//             one-entry holding register with a valid/ack handshake, a sticky
//             overrun flag and a one-cycle framing-error pulse.
//  Revision : 1.0  initial release
// ============================================================================
module rs232_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_sync2;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_deliver, w_deliver_nxt;
  logic             r_frame_err, w_frame_err_nxt;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_bit_last;

  assign w_bit_last = (r_cnt == c_bit_last);

  // Two-stage synchronizer on the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_deliver   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_deliver   <= w_deliver_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Next-state logic: half-bit start re-check, then one sample per bit period.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_deliver_nxt   = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_sync2) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == c_half_last) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          // A line back high at mid start bit was only a glitch.
          w_state_nxt   = r_sync2 ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_last) begin
          w_cnt_nxt              = '0;
          w_shift_nxt[r_bit_idx] = r_sync2;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
          else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_last) begin
          w_cnt_nxt = '0;
          if (r_sync2) begin
            w_deliver_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        // Held-low line (break) reports one error, then waits for idle.
        w_cnt_nxt = '0;
        if (r_sync2) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // One-entry holding register with valid/ack handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_deliver) begin
      r_data  <= r_shift;
      r_valid <= 1'b1;
      if (r_valid && !ack) r_overrun <= 1'b1;
    end else if (r_valid && ack) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rs232_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rs232_rx
//  Purpose  : Scoreboard bench for rs232_rx. Stimulus serialises bytes onto
//             the line and queues the byte the receiver should hand over; an
//             independent monitor pops and compares on each delivery.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rs232_rx;

  localparam int CPB     = 16;
  localparam int HALF    = CPB / 2;
  localparam int CLK_NS  = 10;
  localparam int NOM_LAT = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ack;
  logic       mon_ack;
  logic       tst_ack;
  logic [7:0] data;
  logic       valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  typedef struct {
    logic [7:0] b;
    time        t;
  } exp_t;

  exp_t sb[$];
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   fe_exp  = 0;
  int   fe_seen = 0;
  bit   mon_en  = 1'b1;

  assign ack = mon_ack | tst_ack;

  rs232_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ack       (ack),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #(CLK_NS / 2) clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serialise one 8N1 frame. A low stop bit is extended by hold_bits bit times
  // before the line is released to idle.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold_bits);
    exp_t e;
    rx = 1'b0;
    if (stop_ok && mon_en) begin
      e.b = b;
      e.t = $time;
      sb.push_back(e);
    end
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(CPB);
    end
    rx = stop_ok;
    wait_clk(CPB);
    if (!stop_ok) begin
      fe_exp++;
      wait_clk(hold_bits * CPB);
      rx = 1'b1;
      wait_clk(4);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || valid) && t < 5000) begin
      wait_clk(1);
      t++;
    end
    if (t >= 5000) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d bytes still queued, valid=%0b", sb.size(), valid);
    end
    wait_clk(3);
  endtask

  // Delivery monitor: compare against the queue, then acknowledge the byte.
  initial begin : p_monitor
    exp_t e;
    int   lat;
    mon_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && mon_en && valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_byte: got %02h, expected no delivery", data);
        end else begin
          e   = sb.pop_front();
          lat = int'(($time - e.t) / CLK_NS);
          chk("data", {24'd0, data}, {24'd0, e.b});
          chk("busy_at_valid", {31'd0, busy}, 32'd0);
          chk("overrun_clear", {31'd0, overrun}, 32'd0);
          n_chk++;
          // Measured from the drive time to a negedge sample, so allow one
          // extra cycle beyond the synchronizer-phase tolerance.
          if (lat >= NOM_LAT - 1 && lat <= NOM_LAT + 2) n_pass++;
          else $display("FAIL latency: got %0d clk, expected %0d..%0d", lat, NOM_LAT - 1, NOM_LAT + 2);
        end
        mon_ack = 1'b1;
        @(negedge clk);
        mon_ack = 1'b0;
      end
    end
  end

  // Framing-error monitor: count pulses and require single-cycle width.
  initial begin : p_fe_mon
    logic prev_fe;
    prev_fe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && frame_err) begin
        fe_seen++;
        chk("frame_err_width", {31'd0, prev_fe}, 32'd0);
      end
      prev_fe = frame_err & ~rst;
    end
  end

  initial begin : p_stim
    int fe_before;
    logic [7:0] b;
    bit bad;
    rst     = 1'b1;
    rx      = 1'b1;
    tst_ack = 1'b0;
    wait_clk(3);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_clk(4);

    // Basic frame, then back-to-back pair with acks.
    send_frame(8'h55, 1'b1, 0);
    wait_drain();
    send_frame(8'hA3, 1'b1, 0);
    send_frame(8'h0F, 1'b1, 0);
    wait_drain();

    // Overrun: two deliveries without ack, then one ack clears both flags.
    mon_en = 1'b0;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    wait_clk(4);
    chk("ovr_data", {24'd0, data}, 32'h22);
    chk("ovr_valid", {31'd0, valid}, 32'd1);
    chk("ovr_overrun", {31'd0, overrun}, 32'd1);
    tst_ack = 1'b1;
    wait_clk(1);
    tst_ack = 1'b0;
    chk("ack_valid", {31'd0, valid}, 32'd0);
    chk("ack_overrun", {31'd0, overrun}, 32'd0);
    tst_ack = 1'b1;
    wait_clk(1);
    tst_ack = 1'b0;
    chk("idle_ack_valid", {31'd0, valid}, 32'd0);
    mon_en = 1'b1;

    // Break: bad stop bit held low 40 bit times, then a good frame.
    send_frame(8'h7E, 1'b0, 40);
    chk("break_valid", {31'd0, valid}, 32'd0);
    chk("break_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h3C, 1'b1, 0);
    wait_drain();
    chk("break_fe_count", fe_seen, fe_exp);

    // Short glitch while idle is rejected silently.
    fe_before = fe_seen;
    rx = 1'b0;
    wait_clk(3);
    rx = 1'b1;
    wait_clk(3 * CPB);
    chk("glitch_valid", {31'd0, valid}, 32'd0);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_fe", fe_seen, fe_before);

    // Reset during bit 4 aborts the frame; the next frame is received.
    rx = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      wait_clk(CPB);
    end
    rx = 1'b0;
    wait_clk(HALF);
    rst = 1'b1;
    rx  = 1'b1;
    wait_clk(2);
    chk("mid_rst_data", {24'd0, data}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    chk("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_clk(CPB);
    send_frame(8'hC5, 1'b1, 0);
    wait_drain();

    // Randomized traffic: random bytes, gaps (including none) and bad stops.
    for (int n = 0; n < 24; n++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, !bad, int'($urandom_range(0, 4)));
      wait_clk(int'($urandom_range(0, 20)));
    end
    wait_drain();
    chk("fe_count", fe_seen, fe_exp);
    chk("queue_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
